cpu_control: RTL
================

CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 SHALL have parameter SIZE, default 16, instruction/datapath word width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr  input  SIZE  latched instruction: [15:12] op, [11:8] Rdest/cond, [7:4] opext, [3:0] Rsrc/imm.
REQ-005 SHALL have port flags1  input  2  PSR {F,C}.
REQ-006 SHALL have port flags2  input  3  PSR {Z,N,L}.
REQ-007 SHALL have outputs pc_en, ir_en, MemW1e, MemW2e, RegWe, psr_en, LUIm, Movm  output  1  each: datapath enables/selects.
REQ-008 SHALL have outputs PCm, A2m, RWm  output  2  each: mux selects.
REQ-009 SHALL have output AluOp  output  4  ALU operation code.
REQ-010 SHALL have output halted  output  1  trap indicator, present only with the trap feature.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, EXEC, LD_RD, LD_WB, ST_WR, and HALT when the trap feature is compiled in.
REQ-012 SHALL assert ir_en in FETCH only; DECODE SHALL assert no enable.
REQ-013 SHALL decode and select the next state in DECODE: R/I-type ALU ops, MOV/MOVI, LUI, shifts, Bcond, Jcond, JAL go to EXEC; LOAD goes to LD_RD; STOR goes to ST_WR.
REQ-014 SHALL set mux encodings: PCm 0=nextPc, 1=RegR1, 2=aluOut; A2m 0=RegR2, 1=zero-ext imm4, 2=seImm; RWm 0=MemR2, 1=nextPc, 2=MovMuxOut; LUIm 1=const 8; Movm 0=A2 path, 1=ALU.
REQ-015 SHALL, in EXEC for ALU ops, assert RegWe with RWm=2 and Movm=1. SHALL assert psr_en for ADD/SUB/CMP and their immediates. SHALL suppress RegWe for CMP/CMPI.
REQ-016 SHALL, for MOV/MOVI, assert RegWe with Movm=0 and psr_en=0.
REQ-017 SHALL, for Bcond, drive A2m=2 and an AluOp that adds PC to seImm. PCm SHALL be 2 when the condition is true and 0 otherwise.
REQ-018 SHALL, for Jcond, drive PCm=1 when the condition is true. SHALL, for JAL, drive RWm=1 with RegWe=1 and PCm=1.
REQ-019 SHALL evaluate conditions from cond[3:0]: EQ 0, NE 1, CS 2, CC 3, HI 4, LS 5, GT 6, LE 7, FS 8, FC 9, LO 10, HS 11, LT 12, GE 13, UC 14 (always), 15 (never).
REQ-020 SHALL sample flags combinationally during EXEC, using values registered before the branch.
REQ-021 SHALL have LOAD take FETCH, DECODE, LD_RD, LD_WB (4 cycles), with RegWe and RWm=0 in LD_WB.
REQ-022 SHALL have STOR take FETCH, DECODE, ST_WR (3 cycles), with MemW2e=1 for exactly one cycle.
REQ-023 SHALL have all other instructions take 3 cycles.
REQ-024 SHALL assert pc_en exactly once per instruction, in its final state, then return to FETCH.
REQ-025 SHALL keep MemW1e at 0 (port 1 is fetch-only).
REQ-026 SHALL drive every output to 0 in any state where it is unused.

Reset
REQ-027 SHALL, while reset=0, force state FETCH and drive all outputs to 0 asynchronously.
REQ-028 SHALL ensure a reset mid-instruction produces no further RegWe, MemW2e, psr_en or pc_en pulse for the aborted instruction.
REQ-029 SHALL begin the first FETCH on the first rising clk after reset deasserts.

Configuration
REQ-030 SHALL, with CPU_CONTROL_TRAP_EN defined, send undefined op/opext to HALT from DECODE. HALT SHALL hold halted=1 with all enables 0 until reset.
REQ-031 SHALL, without CPU_CONTROL_TRAP_EN, execute undefined encodings as a 3-cycle NOP (pc_en only), and SHALL omit the halted port.

Structure
REQ-032 SHALL place the op/opext encodings, AluOp codes (ADD, SUB, CMP, AND, OR, XOR, LSH, LUI, PASS), mux-select constants, cond codes and the state enum in shared package cpu_pkg.
REQ-033 SHALL factor condition evaluation into sub-module cond_eval (cond, flags1, flags2 -> take).

Verification
REQ-034 SHALL cover: ADD R1,R2 (0x0152) -> EXEC cycle with RegWe=1, psr_en=1, RWm=2, A2m=0, pc_en=1; total 3 cycles.
REQ-035 SHALL cover: CMPI R3,#5 -> psr_en=1, RegWe=0, A2m=2.
REQ-036 SHALL cover: BEQ -4 with Z=1 -> PCm=2; with Z=0 -> PCm=0; UC always taken; cond 15 never taken.
REQ-037 SHALL cover: LOAD then STOR -> RegWe with RWm=0 on cycle 4 only; MemW2e high exactly 1 cycle on cycle 3.
REQ-038 SHALL cover: JAL R4,R5 -> RegWe=1, RWm=1, PCm=1 in the same cycle.
REQ-039 SHALL cover: reset asserted during LD_RD -> no RegWe; FETCH after release. Opcode 0xF with opext 0xF -> halted=1 (TRAP_EN defined) or a 3-cycle NOP (TRAP_EN undefined).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_control block: opcodes, ALU codes, mux selects, conditions, FSM states.
// The HALT state exists only when CPU_CONTROL_TRAP_EN is defined.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_LUI   = 4'hF;

    localparam logic [3:0] EXT_AND    = 4'h1;
    localparam logic [3:0] EXT_OR     = 4'h2;
    localparam logic [3:0] EXT_XOR    = 4'h3;
    localparam logic [3:0] EXT_ADD    = 4'h5;
    localparam logic [3:0] EXT_SUB    = 4'h9;
    localparam logic [3:0] EXT_CMP    = 4'hB;
    localparam logic [3:0] EXT_MOV    = 4'hD;
    localparam logic [3:0] EXT_LOAD   = 4'h0;
    localparam logic [3:0] EXT_STOR   = 4'h4;
    localparam logic [3:0] EXT_JAL    = 4'h8;
    localparam logic [3:0] EXT_JCOND  = 4'hC;
    localparam logic [3:0] EXT_LSHI_L = 4'h0;
    localparam logic [3:0] EXT_LSHI_R = 4'h1;
    localparam logic [3:0] EXT_LSH    = 4'h4;
    localparam logic [3:0] EXT_LUI    = 4'h0;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_CMP  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_LSH  = 4'd7,
        ALU_LUI  = 4'd8,
        ALU_PASS = 4'd9
    } alu_op_e;

    localparam logic [1:0] PCM_NEXT  = 2'd0;
    localparam logic [1:0] PCM_REG   = 2'd1;
    localparam logic [1:0] PCM_ALU   = 2'd2;
    localparam logic [1:0] A2M_REG   = 2'd0;
    localparam logic [1:0] A2M_IMM4  = 2'd1;
    localparam logic [1:0] A2M_SEIMM = 2'd2;
    localparam logic [1:0] RWM_MEM   = 2'd0;
    localparam logic [1:0] RWM_PC    = 2'd1;
    localparam logic [1:0] RWM_MOV   = 2'd2;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        LD_RD  = 3'd3,
        LD_WB  = 3'd4,
        ST_WR  = 3'd5
`ifdef CPU_CONTROL_TRAP_EN
        , HALT = 3'd6
`endif
    } state_e;

    // cond_pc marks a conditional PC update resolved against live flags in EXEC
    typedef struct packed {
        logic    pc_en;
        logic    ir_en;
        logic    mem_w2e;
        logic    reg_we;
        logic    psr_en;
        logic    lui_m;
        logic    mov_m;
        logic    cond_pc;
        logic [1:0] pc_m;
        logic [1:0] a2m;
        logic [1:0] rwm;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic ctrl_t alu_ctrl(input alu_op_e op, input logic [1:0] a2m,
                                       input logic we, input logic psr);
        ctrl_t c;
        c        = '0;
        c.pc_en  = 1'b1;
        c.alu_op = op;
        c.a2m    = a2m;
        c.reg_we = we;
        c.psr_en = psr;
        c.mov_m  = we;
        c.rwm    = we ? RWM_MOV : RWM_MEM;
        return c;
    endfunction

    function automatic ctrl_t mov_ctrl(input logic [1:0] a2m);
        ctrl_t c;
        c        = '0;
        c.pc_en  = 1'b1;
        c.reg_we = 1'b1;
        c.rwm    = RWM_MOV;
        c.a2m    = a2m;
        return c;
    endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Controller <-> datapath bundle: latched instruction and PSR flags in, enables and mux selects out.
// The halted line exists only when CPU_CONTROL_TRAP_EN is defined.
interface cpu_control_if #(
    parameter int SIZE = 16
);
    logic [SIZE-1:0] instr;
    logic [1:0]      flags1;
    logic [2:0]      flags2;
    logic            pc_en;
    logic            ir_en;
    logic            MemW1e;
    logic            MemW2e;
    logic            RegWe;
    logic            psr_en;
    logic            LUIm;
    logic            Movm;
    logic [1:0]      PCm;
    logic [1:0]      A2m;
    logic [1:0]      RWm;
    logic [3:0]      AluOp;
`ifdef CPU_CONTROL_TRAP_EN
    logic            halted;
`endif

    modport master (
        input  instr, flags1, flags2,
        output pc_en, ir_en, MemW1e, MemW2e, RegWe, psr_en, LUIm, Movm, PCm, A2m, RWm, AluOp
`ifdef CPU_CONTROL_TRAP_EN
        , output halted
`endif
    );

    modport slave (
        output instr, flags1, flags2,
        input  pc_en, ir_en, MemW1e, MemW2e, RegWe, psr_en, LUIm, Movm, PCm, A2m, RWm, AluOp
`ifdef CPU_CONTROL_TRAP_EN
        , input halted
`endif
    );
endinterface

// File: rtl/cpu_control_cond_eval.sv
// Branch/jump condition evaluator: cond field plus PSR flags {F,C} and {Z,N,L} -> take.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [1:0] flags1,
    input  logic [2:0] flags2,
    output logic       take
);
    logic f_s, c_s, z_s, n_s, l_s;

    assign {f_s, c_s}      = flags1;
    assign {z_s, n_s, l_s} = flags2;

    // Condition table; code 15 is the never-taken encoding
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z_s;
            COND_NE: take = !z_s;
            COND_CS: take = c_s;
            COND_CC: take = !c_s;
            COND_HI: take = l_s;
            COND_LS: take = !l_s;
            COND_GT: take = n_s;
            COND_LE: take = !n_s;
            COND_FS: take = f_s;
            COND_FC: take = !f_s;
            COND_LO: take = !l_s && !z_s;
            COND_HS: take = l_s || z_s;
            COND_LT: take = !n_s && !z_s;
            COND_GE: take = n_s || z_s;
            COND_UC: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_control.sv
// Multicycle Moore control FSM for the 16-bit CPU with registered enables and mux selects.
// Define CPU_CONTROL_TRAP_EN to trap undefined encodings into HALT (adds the halted output).
module cpu_control
    import cpu_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic          clk,
    input  logic          reset,
    cpu_control_if.master bus
);
    state_e          state_q, state_d;
    state_e          dec_state_s;
    ctrl_t           ctrl_q, ctrl_d, dec_ctrl_s;
    logic            undef_s;
    logic            take_s;
    logic            unused_s;
    logic [SIZE-1:0] instr_s;
    logic [3:0]      op_s;
    logic [3:0]      ext_s;
`ifdef CPU_CONTROL_TRAP_EN
    logic            halted_q, halted_d;
`endif

    assign instr_s  = bus.instr;
    assign op_s     = instr_s[15:12];
    assign ext_s    = instr_s[7:4];
    assign unused_s = ^instr_s;

    cond_eval u_cond_eval (
        .cond   (instr_s[11:8]),
        .flags1 (bus.flags1),
        .flags2 (bus.flags2),
        .take   (take_s)
    );

    // Instruction decode: EXEC-phase controls and successor state for the latched instruction
    always_comb begin
        dec_ctrl_s  = '0;
        dec_state_s = EXEC;
        undef_s     = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                case (ext_s)
                    EXT_ADD: dec_ctrl_s = alu_ctrl(ALU_ADD, A2M_REG, 1'b1, 1'b1);
                    EXT_SUB: dec_ctrl_s = alu_ctrl(ALU_SUB, A2M_REG, 1'b1, 1'b1);
                    EXT_CMP: dec_ctrl_s = alu_ctrl(ALU_CMP, A2M_REG, 1'b0, 1'b1);
                    EXT_AND: dec_ctrl_s = alu_ctrl(ALU_AND, A2M_REG, 1'b1, 1'b0);
                    EXT_OR:  dec_ctrl_s = alu_ctrl(ALU_OR,  A2M_REG, 1'b1, 1'b0);
                    EXT_XOR: dec_ctrl_s = alu_ctrl(ALU_XOR, A2M_REG, 1'b1, 1'b0);
                    EXT_MOV: dec_ctrl_s = mov_ctrl(A2M_REG);
                    default: undef_s    = 1'b1;
                endcase
            end
            OP_ADDI: dec_ctrl_s = alu_ctrl(ALU_ADD, A2M_SEIMM, 1'b1, 1'b1);
            OP_SUBI: dec_ctrl_s = alu_ctrl(ALU_SUB, A2M_SEIMM, 1'b1, 1'b1);
            OP_CMPI: dec_ctrl_s = alu_ctrl(ALU_CMP, A2M_SEIMM, 1'b0, 1'b1);
            OP_ANDI: dec_ctrl_s = alu_ctrl(ALU_AND, A2M_IMM4, 1'b1, 1'b0);
            OP_ORI:  dec_ctrl_s = alu_ctrl(ALU_OR,  A2M_IMM4, 1'b1, 1'b0);
            OP_XORI: dec_ctrl_s = alu_ctrl(ALU_XOR, A2M_IMM4, 1'b1, 1'b0);
            OP_MOVI: dec_ctrl_s = mov_ctrl(A2M_SEIMM);
            OP_SHIFT: begin
                case (ext_s)
                    EXT_LSH:    dec_ctrl_s = alu_ctrl(ALU_LSH, A2M_REG, 1'b1, 1'b0);
                    EXT_LSHI_L: dec_ctrl_s = alu_ctrl(ALU_LSH, A2M_IMM4, 1'b1, 1'b0);
                    EXT_LSHI_R: dec_ctrl_s = alu_ctrl(ALU_LSH, A2M_IMM4, 1'b1, 1'b0);
                    default:    undef_s    = 1'b1;
                endcase
            end
            OP_LUI: begin
                if (ext_s == EXT_LUI) begin
                    dec_ctrl_s       = alu_ctrl(ALU_LUI, A2M_IMM4, 1'b1, 1'b0);
                    dec_ctrl_s.lui_m = 1'b1;
                end else begin
                    undef_s = 1'b1;
                end
            end
            OP_BCOND: begin
                dec_ctrl_s.pc_en   = 1'b1;
                dec_ctrl_s.a2m     = A2M_SEIMM;
                dec_ctrl_s.alu_op  = ALU_ADD;
                dec_ctrl_s.pc_m    = PCM_ALU;
                dec_ctrl_s.cond_pc = 1'b1;
            end
            OP_MEM: begin
                case (ext_s)
                    EXT_LOAD: dec_state_s = LD_RD;
                    EXT_STOR: begin
                        dec_state_s        = ST_WR;
                        dec_ctrl_s.pc_en   = 1'b1;
                        dec_ctrl_s.mem_w2e = 1'b1;
                    end
                    EXT_JAL: begin
                        dec_ctrl_s.pc_en  = 1'b1;
                        dec_ctrl_s.reg_we = 1'b1;
                        dec_ctrl_s.rwm    = RWM_PC;
                        dec_ctrl_s.pc_m   = PCM_REG;
                    end
                    EXT_JCOND: begin
                        dec_ctrl_s.pc_en   = 1'b1;
                        dec_ctrl_s.pc_m    = PCM_REG;
                        dec_ctrl_s.cond_pc = 1'b1;
                    end
                    default: undef_s = 1'b1;
                endcase
            end
            default: undef_s = 1'b1;
        endcase
    end

    // Next state and next registered outputs; outputs are computed for the state being entered
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        case (state_q)
            FETCH: begin
                // ir_en low here only in the idle cycle right after reset
                if (ctrl_q.ir_en) begin
                    state_d = DECODE;
                end else begin
                    ctrl_d.ir_en = 1'b1;
                end
            end
            DECODE: begin
                if (undef_s) begin
`ifdef CPU_CONTROL_TRAP_EN
                    state_d = HALT;
`else
                    state_d      = EXEC;
                    ctrl_d.pc_en = 1'b1;
`endif
                end else begin
                    state_d = dec_state_s;
                    ctrl_d  = dec_ctrl_s;
                end
            end
            LD_RD: begin
                state_d       = LD_WB;
                ctrl_d.pc_en  = 1'b1;
                ctrl_d.reg_we = 1'b1;
                ctrl_d.rwm    = RWM_MEM;
            end
            EXEC, LD_WB, ST_WR: begin
                state_d      = FETCH;
                ctrl_d.ir_en = 1'b1;
            end
`ifdef CPU_CONTROL_TRAP_EN
            HALT: state_d = HALT;
`endif
            default: state_d = FETCH;
        endcase
`ifdef CPU_CONTROL_TRAP_EN
        halted_d = (state_d == HALT);
`endif
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            ctrl_q   <= '0;
`ifdef CPU_CONTROL_TRAP_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
`ifdef CPU_CONTROL_TRAP_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign bus.pc_en  = ctrl_q.pc_en;
    assign bus.ir_en  = ctrl_q.ir_en;
    assign bus.MemW1e = 1'b0;
    assign bus.MemW2e = ctrl_q.mem_w2e;
    assign bus.RegWe  = ctrl_q.reg_we;
    assign bus.psr_en = ctrl_q.psr_en;
    assign bus.LUIm   = ctrl_q.lui_m;
    assign bus.Movm   = ctrl_q.mov_m;
    assign bus.A2m    = ctrl_q.a2m;
    assign bus.RWm    = ctrl_q.rwm;
    assign bus.AluOp  = ctrl_q.alu_op;
    // Conditional PC select resolves against the live PSR flags during EXEC
    assign bus.PCm    = (ctrl_q.cond_pc && !take_s) ? PCM_NEXT : ctrl_q.pc_m;
`ifdef CPU_CONTROL_TRAP_EN
    assign bus.halted = halted_q;
`endif
endmodule
